// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - state encodings and LED pattern constants for the countdown-timer controller
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_MIN = 3'd1,
        ST_SET_SEC = 3'd2,
        ST_RUN     = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Wide enough for any supported LED bus; the top slices down to LED_W.
    localparam int LED_W_MAX = 64;
    localparam logic [LED_W_MAX-1:0] LED_ALL_ON  = '1;
    localparam logic [LED_W_MAX-1:0] LED_ALL_OFF = '0;

endpackage

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - countdown-timer sequencing FSM with registered pulse outputs and alarm LEDs
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int DONE_SECS = 10,
    parameter int LED_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             btn_set,
    input  logic             btn_inc,
    input  logic             btn_start,
    input  logic             zero,
    output logic             setting,
    output logic             inc_min,
    output logic             inc_sec,
    output logic             load,
    output logic             count_en,
    output logic [LED_W-1:0] led,
    output logic [2:0]       state
);

    localparam int CNT_W = $clog2(DONE_SECS + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_inc_min, r_inc_sec, r_load, r_count_en;
    logic               w_inc_min_next, w_inc_sec_next, w_load_next, w_count_en_next;
    logic [LED_W-1:0]   r_led, w_led_next;
    logic [CNT_W-1:0]   r_done_cnt, w_done_cnt_next, w_cnt_inc;
    logic               w_any_btn, w_done_reached, w_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_inc_min  <= 1'b0;
            r_inc_sec  <= 1'b0;
            r_load     <= 1'b0;
            r_count_en <= 1'b0;
            r_led      <= LED_ALL_OFF[LED_W-1:0];
            r_done_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inc_min  <= w_inc_min_next;
            r_inc_sec  <= w_inc_sec_next;
            r_load     <= w_load_next;
            r_count_en <= w_count_en_next;
            r_led      <= w_led_next;
            r_done_cnt <= w_done_cnt_next;
        end
    end

    always_comb begin
        w_any_btn = btn_start | btn_set | btn_inc;
        w_cnt_inc = (r_done_cnt == CNT_W'(DONE_SECS)) ? r_done_cnt : r_done_cnt + 1'b1;
        w_done_reached = tick_1hz && (w_cnt_inc >= CNT_W'(DONE_SECS));
        // zero lags one edge behind count_en, so expiry waits for a quiet cycle
        w_expire = zero && !r_count_en;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (btn_start) begin
                    if (!zero) w_state_next = ST_RUN;
                end else if (btn_set) begin
                    w_state_next = ST_SET_MIN;
                end
            end
            ST_SET_MIN: if (btn_set) w_state_next = ST_SET_SEC;
            ST_SET_SEC: if (btn_set) w_state_next = ST_IDLE;
            ST_RUN: begin
                if (btn_start)     w_state_next = ST_PAUSE;
                else if (w_expire) w_state_next = ST_DONE;
            end
            ST_PAUSE: begin
                if (btn_start) begin
                    if (!zero) w_state_next = ST_RUN;
                end else if (btn_set) begin
                    w_state_next = ST_SET_MIN;
                end
            end
            ST_DONE: if (w_any_btn || w_done_reached) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_inc_min_next  = (r_state == ST_SET_MIN) && !btn_set && btn_inc;
        w_inc_sec_next  = (r_state == ST_SET_SEC) && !btn_set && btn_inc;
        w_load_next     = (r_state == ST_SET_SEC) && btn_set;
        w_count_en_next = (r_state == ST_RUN) && !btn_start && !w_expire && tick_1hz;

        w_led_next      = LED_ALL_OFF[LED_W-1:0];
        w_done_cnt_next = '0;
        if (w_state_next == ST_DONE) begin
            if (r_state != ST_DONE) begin
                w_led_next = LED_ALL_ON[LED_W-1:0];
            end else if (tick_1hz) begin
                w_led_next      = ~r_led;
                w_done_cnt_next = w_cnt_inc;
            end else begin
                w_led_next      = r_led;
                w_done_cnt_next = r_done_cnt;
            end
        end
    end

    assign setting  = (r_state == ST_SET_MIN) || (r_state == ST_SET_SEC);
    assign state    = r_state;
    assign inc_min  = r_inc_min;
    assign inc_sec  = r_inc_sec;
    assign load     = r_load;
    assign count_en = r_count_en;
    assign led      = r_led;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - randomized and directed self-checking bench for timer_ctrl
module tb_timer_ctrl;

    localparam int DS = 10;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_1hz = 1'b0, btn_set = 1'b0, btn_inc = 1'b0, btn_start = 1'b0, zero = 1'b1;
    logic setting, inc_min, inc_sec, load, count_en;
    logic [LW-1:0] led;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int n_imin = 0, n_isec = 0, n_load = 0, n_ce = 0;

    timer_ctrl #(.DONE_SECS(DS), .LED_W(LW)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_set(btn_set), .btn_inc(btn_inc),
        .btn_start(btn_start), .zero(zero), .setting(setting), .inc_min(inc_min),
        .inc_sec(inc_sec), .load(load), .count_en(count_en), .led(led), .state(state)
    );

    always #5 clk = ~clk;

    // Reference: mode numbers follow the published state table
    typedef struct packed {
        logic [2:0]  st;
        logic        imin, isec, ld, ce;
        logic [15:0] led;
        int unsigned cnt;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(mdl_t c, logic s, logic i, logic g, logic t, logic z);
        mdl_t n;
        n = c;
        n.imin = 0; n.isec = 0; n.ld = 0; n.ce = 0;
        case (c.st)
            3'd0: if (g) n.st = z ? 3'd0 : 3'd3; else if (s) n.st = 3'd1;
            3'd1: if (s) n.st = 3'd2; else if (i) n.imin = 1;
            3'd2: if (s) begin n.st = 3'd0; n.ld = 1; end else if (i) n.isec = 1;
            3'd3: if (g) n.st = 3'd4; else if (z && !c.ce) n.st = 3'd5; else if (t) n.ce = 1;
            3'd4: if (g) begin if (!z) n.st = 3'd3; end else if (s) n.st = 3'd1;
            3'd5: begin
                if (s || i || g) n.st = 3'd0;
                else if (t) begin
                    n.cnt = c.cnt + 1;
                    if (n.cnt >= DS) n.st = 3'd0;
                    else n.led = ~c.led;
                end
            end
            default: n.st = 3'd0;
        endcase
        if (n.st == 3'd5 && c.st != 3'd5) begin n.led = 16'hFFFF; n.cnt = 0; end
        if (n.st != 3'd5) begin n.led = 16'h0000; n.cnt = 0; end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= step(m, btn_set, btn_inc, btn_start, tick_1hz, zero);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("state", 32'(state), 32'(m.st));
        chk("setting", 32'(setting), 32'(m.st == 3'd1 || m.st == 3'd2));
        chk("inc_min", 32'(inc_min), 32'(m.imin));
        chk("inc_sec", 32'(inc_sec), 32'(m.isec));
        chk("load", 32'(load), 32'(m.ld));
        chk("count_en", 32'(count_en), 32'(m.ce));
        chk("led", 32'(led), 32'(m.led));
        if (inc_min) n_imin++;
        if (inc_sec) n_isec++;
        if (load) n_load++;
        if (count_en) n_ce++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic i, input logic g, input logic t);
        btn_set = s; btn_inc = i; btn_start = g; tick_1hz = t;
        cyc();
        btn_set = 0; btn_inc = 0; btn_start = 0; tick_1hz = 0;
    endtask

    initial begin
        int ce0;
        repeat (3) cyc();
        rst = 0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'({setting, inc_min, inc_sec, load, count_en}), 32'd0);
        chk("rst_led", 32'(led), 32'd0);

        // start with zero held: nothing happens
        zero = 1;
        pulse(0, 0, 1, 0);
        pulse(0, 0, 0, 1);
        cyc();
        chk("idle_zero_state", 32'(state), 32'd0);
        chk("idle_zero_ce", 32'(n_ce), 32'd0);

        // set sequence
        pulse(1, 0, 0, 0);
        chk("set_min", 32'(state), 32'd1);
        for (int k = 0; k < 3; k++) begin
            pulse(0, 1, 0, 0);
            chk("inc_min_lat", 32'(inc_min), 32'd1);
            chk("setting_hi", 32'(setting), 32'd1);
        end
        pulse(1, 0, 0, 0);
        chk("set_sec", 32'(state), 32'd2);
        for (int k = 0; k < 2; k++) begin
            pulse(0, 1, 0, 0);
            chk("inc_sec_lat", 32'(inc_sec), 32'd1);
        end
        pulse(1, 0, 0, 0);
        chk("load_lat", 32'({load, setting}), 32'b10);
        chk("set_done_state", 32'(state), 32'd0);
        cyc();
        chk("n_inc_min", 32'(n_imin), 32'd3);
        chk("n_inc_sec", 32'(n_isec), 32'd2);
        chk("n_load", 32'(n_load), 32'd1);

        // run / pause
        zero = 0;
        pulse(0, 0, 1, 0);
        chk("run", 32'(state), 32'd3);
        ce0 = n_ce;
        for (int k = 0; k < 5; k++) begin
            pulse(0, 0, 0, 1);
            cyc();
        end
        chk("five_ticks", 32'(n_ce - ce0), 32'd5);
        pulse(0, 0, 1, 1);
        chk("pause", 32'({state, count_en}), 32'({3'd4, 1'b0}));
        for (int k = 0; k < 3; k++) pulse(0, 0, 0, 1);
        cyc();
        chk("pause_no_ce", 32'(n_ce - ce0), 32'd5);
        pulse(0, 0, 1, 0);
        chk("resume", 32'(state), 32'd3);

        // expiry
        pulse(0, 0, 0, 1);
        cyc();
        zero = 1;
        cyc();
        chk("done_entry", 32'(state), 32'd5);
        chk("done_led", 32'(led), 32'h0000FFFF);
        pulse(0, 0, 0, 1);
        chk("led_toggle", 32'(led), 32'd0);
        for (int k = 1; k < DS; k++) begin
            cyc();
            pulse(0, 0, 0, 1);
        end
        chk("auto_idle", 32'({state, led}), 32'd0);

        // acknowledge, then priority
        zero = 0;
        pulse(0, 0, 1, 0);
        zero = 1;
        cyc(); cyc();
        chk("done_again", 32'(state), 32'd5);
        pulse(0, 1, 0, 0);
        chk("ack_idle", 32'(state), 32'd0);
        zero = 0;
        pulse(1, 0, 1, 0);
        chk("prio_run", 32'(state), 32'd3);

        // asynchronous reset mid-run
        pulse(0, 0, 0, 1);
        #3 rst = 1;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_led_ce", 32'({led, count_en}), 32'd0);
        cyc();
        rst = 0;

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            btn_set   = ($urandom_range(0, 9) == 0);
            btn_inc   = ($urandom_range(0, 6) == 0);
            btn_start = ($urandom_range(0, 11) == 0);
            tick_1hz  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 14) == 0) zero = ~zero;
            rst = ($urandom_range(0, 599) == 0);
            cyc();
        end
        btn_set = 0; btn_inc = 0; btn_start = 0; tick_1hz = 0; rst = 0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
